// File: rtl/rssb_pkg.sv
// Shared types and helpers for the RSSB sequencer and its datapath partner.
package rssb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4,
    HALT   = 3'd5
  } seq_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AW    = 8;

  // Returns {borrow, result}: the extra top bit of the widened difference is the borrow.
  function automatic logic [DEF_WIDTH:0] rssb_sub(input logic [DEF_WIDTH-1:0] mem,
                                                  input logic [DEF_WIDTH-1:0] acc);
    return {1'b0, mem} - {1'b0, acc};
  endfunction

endpackage

// File: rtl/rssb_seq_if.sv
// Data-memory request/ack port between the sequencer (master) and the memory datapath (slave).
interface rssb_seq_if
  import rssb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
);
  logic             mem_req;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/rssb_alu.sv
// Combinational reverse subtractor: result = mem - acc, borrow when mem < acc (unsigned).
module rssb_alu #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_mem,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0] o_result,
  output logic             o_borrow
);
  logic [WIDTH:0] w_diff;

  assign w_diff   = {1'b0, i_mem} - {1'b0, i_acc};
  assign o_result = w_diff[WIDTH-1:0];
  assign o_borrow = w_diff[WIDTH];
endmodule

// File: rtl/rssb_seq.sv
// RSSB instruction sequencer: fetches operand address from ROM, then read-modify-writes
// data memory over a req/ack port; at most one request outstanding, any number of wait states.
module rssb_seq
  import rssb_pkg::*;
#(
  parameter int            WIDTH     = DEF_WIDTH,
  parameter int            AW        = DEF_AW,
  parameter logic [AW-1:0] HALT_ADDR = {AW{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [AW-1:0]    rom_addr,
  input  logic [AW-1:0]    rom_data,
  rssb_seq_if.master       bus,
  output logic [WIDTH-1:0] acc,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             halted
);
  localparam logic [2:0] S_IDLE   = IDLE;
  localparam logic [2:0] S_FETCH  = FETCH;
  localparam logic [2:0] S_DECODE = DECODE;
  localparam logic [2:0] S_READ   = READ;
  localparam logic [2:0] S_WRITE  = WRITE;
  localparam logic [2:0] S_HALT   = HALT;

  logic [2:0]       r_state;
  logic [AW-1:0]    r_pc;
  logic [WIDTH-1:0] r_acc;
  logic [AW-1:0]    r_op;
  logic             r_req;
  logic             r_we;
  logic [WIDTH-1:0] r_wdata;
  logic             r_borrow;
  logic             r_busy;
  logic             r_halted;

  logic [WIDTH-1:0] w_result;
  logic             w_borrow;

  rssb_alu #(.WIDTH(WIDTH)) u_alu (
    .i_mem    (bus.mem_rdata),
    .i_acc    (r_acc),
    .o_result (w_result),
    .o_borrow (w_borrow)
  );

  // The latched operand doubles as the memory address for both halves of the RMW.
  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_op;
  assign bus.mem_wdata = r_wdata;
  assign rom_addr      = r_pc;
  assign pc            = r_pc;
  assign acc           = r_acc;
  assign busy          = r_busy;
  assign halted        = r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_acc    <= '0;
      r_op     <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_op <= rom_data;
          if (rom_data == HALT_ADDR) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // req stays high; only we flips so the write follows without a bubble
          if (bus.mem_ack) begin
            r_acc    <= w_result;
            r_borrow <= w_borrow;
            r_wdata  <= w_result;
            r_we     <= 1'b1;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.mem_ack) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_pc    <= r_pc + (r_borrow ? AW'(2) : AW'(1));
            r_state <= S_FETCH;
          end
        end
        S_HALT: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rssb_seq.sv
// Self-checking bench for rssb_seq: ROM and memory responder models plus an instruction-level reference.
module tb_rssb_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] rom_addr, rom_data, acc, pc;
  logic       busy, halted;

  rssb_seq_if #(.WIDTH(8), .AW(8)) bus ();

  rssb_seq #(.WIDTH(8), .AW(8), .HALT_ADDR(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .bus      (bus.master),
    .acc      (acc),
    .pc       (pc),
    .busy     (busy),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  logic [7:0] mem [256];
  logic [7:0] mdl_mem [256];

  int checks = 0;
  int failures = 0;

  // responder controls / observations
  int  delay = 0;
  bit  rnd_delay = 0;
  bit  spurious = 0;
  int  viol = 0;
  int  req_cycles = 0;
  bit  in_txn = 0;
  int  cnt = 0;
  int  cur_delay = 0;
  logic [7:0] s_addr;
  logic       s_we;
  logic [7:0] wq_addr [$];
  logic [7:0] wq_data [$];
  time        wq_t [$];

  // model state
  int m_pc, m_acc;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (bus.mem_req === 1'b1) begin
      req_cycles++;
      if (!in_txn) begin
        in_txn    = 1;
        cnt       = 0;
        cur_delay = rnd_delay ? int'($urandom_range(0, 3)) : delay;
        s_addr    = bus.mem_addr;
        s_we      = bus.mem_we;
      end else if (bus.mem_addr !== s_addr || bus.mem_we !== s_we) begin
        viol++;
      end
      if (cnt == cur_delay) begin
        bus.mem_ack = 1'b1;
        in_txn = 0;
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          wq_addr.push_back(bus.mem_addr);
          wq_data.push_back(bus.mem_wdata);
          wq_t.push_back($time);
        end else begin
          bus.mem_rdata = mem[bus.mem_addr];
        end
      end else begin
        cnt++;
      end
    end else begin
      in_txn = 0;
      if (spurious) bus.mem_ack = 1'b1;
    end
  end

  task automatic do_reset();
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    wq_t.delete();
    for (int i = 0; i < 256; i++) mdl_mem[i] = mem[i];
    m_pc  = 0;
    m_acc = 0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'($urandom_range(0, 254));
      mem[i] = 8'($urandom);
    end
  endtask

  // Executes n instructions in the reference and checks each write and the resulting pc/acc.
  task automatic run_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int op, val, res, waited;
      bit b;
      logic [7:0] a, d;
      op  = rom[m_pc];
      val = mdl_mem[op];
      b   = val < m_acc;
      res = (val - m_acc + 256) % 256;
      mdl_mem[op] = 8'(res);
      m_acc = res;
      m_pc  = (m_pc + (b ? 2 : 1)) % 256;
      waited = 0;
      while (wq_addr.size() == 0 && waited < 200) begin
        @(posedge clk); #1;
        waited++;
      end
      checks++;
      if (wq_addr.size() == 0) begin
        failures++;
        $display("FAIL %s instr %0d: no write within 200 cycles", tag, i);
        return;
      end
      a = wq_addr.pop_front();
      d = wq_data.pop_front();
      if (a !== 8'(op) || d !== 8'(res)) begin
        failures++;
        $display("FAIL %s write %0d: got addr=%h data=%h, expected addr=%h data=%h", tag, i, a, d, 8'(op), 8'(res));
      end
      checks++;
      if (pc !== 8'(m_pc) || acc !== 8'(m_acc)) begin
        failures++;
        $display("FAIL %s state %0d: got pc=%h acc=%h, expected pc=%h acc=%h", tag, i, pc, acc, 8'(m_pc), 8'(m_acc));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, pc, acc, rom_addr, busy, halted} !== '0) begin
      failures++;
      $display("FAIL reset_state: got req=%b we=%b addr=%h wdata=%h pc=%h acc=%h rom_addr=%h busy=%b halted=%b, expected all zero",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, pc, acc, rom_addr, busy, halted);
    end
  endtask

  task automatic test_reset_midread();
    int waited = 0;
    fill_random();
    rom[0] = 8'h05; mem[5] = 8'd10; rom[1] = 8'h06;
    delay = 0;
    do_reset();
    start = 1'b1;
    run_check(1, "midread_pre");
    delay = 1000;
    while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b0) && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midread_pending: got req=%b busy=%b, expected req=1 busy=1", bus.mem_req, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || pc !== 8'h00 || acc !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midread_async_reset: got req=%b pc=%h acc=%h busy=%b, expected 0/00/00/0", bus.mem_req, pc, acc, busy);
    end
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    delay = 0;
    req_cycles = 0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || req_cycles !== 0) begin
      failures++;
      $display("FAIL midread_idle: got busy=%b req_cycles=%0d, expected 0/0", busy, req_cycles);
    end
  endtask

  task automatic test_basic();
    time t1, t2;
    fill_random();
    rom[0] = 8'h05; mem[5] = 8'd10;
    rom[1] = 8'h06; mem[6] = 8'd3;
    delay = 0;
    do_reset();
    start = 1'b1;
    run_check(1, "basic1");
    t1 = wq_t.pop_front();
    run_check(1, "basic2");
    t2 = wq_t.pop_front();
    checks++;
    if (mem[5] !== 8'd10 || mem[6] !== 8'hF9 || acc !== 8'hF9 || pc !== 8'h03) begin
      failures++;
      $display("FAIL basic_values: got mem5=%h mem6=%h acc=%h pc=%h, expected 0a/f9/f9/03", mem[5], mem[6], acc, pc);
    end
    checks++;
    if (t2 - t1 != 40) begin
      failures++;
      $display("FAIL basic_instr_time: got %0t between writes, expected 40 (4 cycles)", t2 - t1);
    end
  endtask

  task automatic test_wait_states();
    fill_random();
    delay = 3;
    spurious = 1;
    viol = 0;
    do_reset();
    start = 1'b1;
    run_check(6, "wait3");
    spurious = 0;
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL wait3_stable: got %0d req/addr/we changes during waits, expected 0", viol);
    end
    delay = 0;
  endtask

  task automatic test_random();
    fill_random();
    rnd_delay = 1;
    viol = 0;
    do_reset();
    start = 1'b1;
    run_check(20, "random");
    rnd_delay = 0;
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL random_stable: got %0d changes during waits, expected 0", viol);
    end
  endtask

  task automatic test_wrap(input logic [7:0] m7, input logic [7:0] exp_pc, input logic [7:0] exp_acc);
    for (int i = 0; i < 254; i++) rom[i] = 8'h80;
    rom[254] = 8'h81; rom[255] = 8'h07;
    mem[8'h80] = 8'h00; mem[8'h81] = 8'h02; mem[7] = m7;
    delay = 0;
    do_reset();
    start = 1'b1;
    run_check(256, "wrap");
    checks++;
    if (pc !== exp_pc || acc !== exp_acc) begin
      failures++;
      $display("FAIL wrap_m7_%h: got pc=%h acc=%h, expected pc=%h acc=%h", m7, pc, acc, exp_pc, exp_acc);
    end
  endtask

  task automatic test_halt();
    fill_random();
    rom[0] = 8'h10; mem[8'h10] = 8'd4; rom[1] = 8'hFF;
    delay = 0;
    do_reset();
    start = 1'b1;
    run_check(1, "halt_pre");
    req_cycles = 0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h01 || acc !== 8'h04 || req_cycles !== 0) begin
      failures++;
      $display("FAIL halt_enter: got halted=%b busy=%b pc=%h acc=%h reqs=%0d, expected 1/0/01/04/0", halted, busy, pc, acc, req_cycles);
    end
    for (int i = 0; i < 8; i++) begin
      start = ~start;
      @(posedge clk); #1;
    end
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h01 || req_cycles !== 0) begin
      failures++;
      $display("FAIL halt_sticky: got halted=%b busy=%b pc=%h reqs=%0d, expected 1/0/01/0", halted, busy, pc, req_cycles);
    end
    do_reset();
    checks++;
    if (halted !== 1'b0 || pc !== 8'h00) begin
      failures++;
      $display("FAIL halt_reset: got halted=%b pc=%h, expected 0/00", halted, pc);
    end
  endtask

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h00;
      mem[i] = 8'h00;
    end
    test_reset();
    test_reset_midread();
    test_basic();
    test_wait_states();
    test_random();
    test_wrap(8'h01, 8'h01, 8'hFF);
    test_wrap(8'h02, 8'h00, 8'h00);
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
